// File: rtl/perf_counter_unit_pkg.sv
// Shared types for perf_counter_unit: counter layout, stream index, FSM state.
package perf_counter_unit_pkg;

  localparam int unsigned COUNTER_WIDTH     = 32;
  localparam int unsigned MEM_LANES         = 2;
  localparam int unsigned INT_LANES         = 2;
  localparam int unsigned DEC_LANES         = 2;
  localparam int unsigned NUM_PERF_COUNTERS = 7;

  typedef logic [COUNTER_WIDTH-1:0] DataPath;

  typedef struct packed {
    DataPath numIC_Miss;
    DataPath numLoadMiss;
    DataPath numStoreMiss;
    DataPath numStoreLoadForwardingFail;
    DataPath numMemDepPredMiss;
    DataPath numBranchPredMiss;
    DataPath numBranchPredMissDetectedOnDecode;
  } PerfCounterPath;

  // Stream word order; matches the member order of PerfCounterPath.
  typedef enum logic [2:0] {
    PerfIcMiss                         = 3'd0,
    PerfLoadMiss                       = 3'd1,
    PerfStoreMiss                      = 3'd2,
    PerfStoreLoadForwardingFail        = 3'd3,
    PerfMemDepPredMiss                 = 3'd4,
    PerfBranchPredMiss                 = 3'd5,
    PerfBranchPredMissDetectedOnDecode = 3'd6
  } PerfCounterIndex;

  // Indexable view of PerfCounterPath: the first member lands in the top element.
  typedef logic [NUM_PERF_COUNTERS-1:0][COUNTER_WIDTH-1:0] CounterVec;

  localparam logic [2:0] LAST_IDX = 3'(PerfBranchPredMissDetectedOnDecode);

  typedef enum logic {StIdle, StStream} snap_state_e;

endpackage

// File: rtl/perf_counter_unit_if.sv
// Snapshot stream: one counter word per valid/ready transfer.
interface perf_counter_unit_if;
  import perf_counter_unit_pkg::*;

  logic       snapOutValid;
  logic       snapOutReady;
  logic [2:0] snapOutIndex;
  DataPath    snapOutData;
  logic       snapOutLast;

  modport master (
    output snapOutValid, snapOutIndex, snapOutData, snapOutLast,
    input  snapOutReady
  );

  modport slave (
    input  snapOutValid, snapOutIndex, snapOutData, snapOutLast,
    output snapOutReady
  );
endinterface

// File: rtl/perf_event_accumulator.sv
// One performance counter: adds the popcount of a lane vector each enabled cycle.
// RSD_PERF_COUNTER_SATURATE_EN: saturate at all-ones instead of wrapping.
module perf_event_accumulator
  import perf_counter_unit_pkg::*;
#(
  parameter int unsigned Lanes = 2
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             i_count_en,
  input  logic             i_clear,
  input  logic [Lanes-1:0] i_events,
  output DataPath          o_count
);

  DataPath r_count;
  DataPath w_inc;
  DataPath w_next;

  // Popcount of the lane vector, zero-extended to the counter width.
  always_comb begin
    w_inc = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      w_inc = w_inc + DataPath'(i_events[i]);
    end
  end

`ifdef RSD_PERF_COUNTER_SATURATE_EN
  logic [COUNTER_WIDTH:0] w_sum;
  assign w_sum  = {1'b0, r_count} + {1'b0, w_inc};
  assign w_next = w_sum[COUNTER_WIDTH] ? '1 : w_sum[COUNTER_WIDTH-1:0];
`else
  assign w_next = r_count + w_inc;
`endif

  // Counter register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/perf_counter_unit.sv
// Seven performance counters with live output and a frozen snapshot stream.
// RSD_PERF_COUNTER_SATURATE_EN: counters saturate instead of wrapping.
module perf_counter_unit
  import perf_counter_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 countEnable,
  input  logic                 icMiss,
  input  logic [MEM_LANES-1:0] loadMiss,
  input  logic                 storeMiss,
  input  logic [MEM_LANES-1:0] storeLoadForwardingFail,
  input  logic [MEM_LANES-1:0] memDepPredMiss,
  input  logic [INT_LANES-1:0] branchPredMiss,
  input  logic [DEC_LANES-1:0] branchPredMissDetectedOnDecode,
  input  logic                 clearReq,
  input  logic                 snapshotReq,
  output logic                 snapshotBusy,
  perf_counter_unit_if.master  snap,
  output PerfCounterPath       perfCounter
);

  perf_event_accumulator #(.Lanes(1)) u_acc_ic_miss (
    .clk(clk), .rstN(rstN), .i_count_en(countEnable), .i_clear(clearReq),
    .i_events(icMiss), .o_count(perfCounter.numIC_Miss));

  perf_event_accumulator #(.Lanes(MEM_LANES)) u_acc_load_miss (
    .clk(clk), .rstN(rstN), .i_count_en(countEnable), .i_clear(clearReq),
    .i_events(loadMiss), .o_count(perfCounter.numLoadMiss));

  perf_event_accumulator #(.Lanes(1)) u_acc_store_miss (
    .clk(clk), .rstN(rstN), .i_count_en(countEnable), .i_clear(clearReq),
    .i_events(storeMiss), .o_count(perfCounter.numStoreMiss));

  perf_event_accumulator #(.Lanes(MEM_LANES)) u_acc_slf_fail (
    .clk(clk), .rstN(rstN), .i_count_en(countEnable), .i_clear(clearReq),
    .i_events(storeLoadForwardingFail), .o_count(perfCounter.numStoreLoadForwardingFail));

  perf_event_accumulator #(.Lanes(MEM_LANES)) u_acc_mem_dep (
    .clk(clk), .rstN(rstN), .i_count_en(countEnable), .i_clear(clearReq),
    .i_events(memDepPredMiss), .o_count(perfCounter.numMemDepPredMiss));

  perf_event_accumulator #(.Lanes(INT_LANES)) u_acc_br_miss (
    .clk(clk), .rstN(rstN), .i_count_en(countEnable), .i_clear(clearReq),
    .i_events(branchPredMiss), .o_count(perfCounter.numBranchPredMiss));

  perf_event_accumulator #(.Lanes(DEC_LANES)) u_acc_br_miss_dec (
    .clk(clk), .rstN(rstN), .i_count_en(countEnable), .i_clear(clearReq),
    .i_events(branchPredMissDetectedOnDecode),
    .o_count(perfCounter.numBranchPredMissDetectedOnDecode));

  snap_state_e    r_state, w_state_next;
  logic [2:0]     r_word_idx, w_word_idx_next;
  logic           w_capture;
  PerfCounterPath r_shadow;
  CounterVec      w_shadow_vec;
  logic [2:0]     w_vec_sel;

  // State and word index registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= StIdle;
      r_word_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_word_idx <= w_word_idx_next;
    end
  end

  // Next state: capture on request when idle, advance one word per transfer.
  always_comb begin
    w_state_next    = r_state;
    w_word_idx_next = r_word_idx;
    w_capture       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (snapshotReq) begin
          w_capture       = 1'b1;
          w_state_next    = StStream;
          w_word_idx_next = '0;
        end
      end
      StStream: begin
        if (snap.snapOutReady) begin
          if (r_word_idx == LAST_IDX) begin
            w_state_next    = StIdle;
            w_word_idx_next = '0;
          end else begin
            w_word_idx_next = r_word_idx + 3'd1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Shadow copy takes the register values, i.e. before this cycle's increment or clear.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_shadow <= '0;
    end else if (w_capture) begin
      r_shadow <= perfCounter;
    end
  end

  assign w_shadow_vec = r_shadow;
  assign w_vec_sel    = LAST_IDX - r_word_idx;

  assign snapshotBusy      = (r_state == StStream);
  assign snap.snapOutValid = (r_state == StStream);
  assign snap.snapOutIndex = r_word_idx;
  assign snap.snapOutData  = (r_state == StStream) ? w_shadow_vec[w_vec_sel] : '0;
  assign snap.snapOutLast  = (r_state == StStream) && (r_word_idx == LAST_IDX);

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: directed steps plus random traffic, checked
// against a queue-based model of the counters and the snapshot stream.
module tb_perf_counter_unit;
  import perf_counter_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rstN, countEnable, icMiss, storeMiss, clearReq, snapshotReq;
  logic                 snapshotBusy;
  logic [MEM_LANES-1:0] loadMiss, storeLoadForwardingFail, memDepPredMiss;
  logic [INT_LANES-1:0] branchPredMiss;
  logic [DEC_LANES-1:0] branchPredMissDetectedOnDecode;
  PerfCounterPath       perfCounter;

  perf_counter_unit_if u_snap ();

  perf_counter_unit dut (
    .clk(clk), .rstN(rstN), .countEnable(countEnable), .icMiss(icMiss),
    .loadMiss(loadMiss), .storeMiss(storeMiss),
    .storeLoadForwardingFail(storeLoadForwardingFail), .memDepPredMiss(memDepPredMiss),
    .branchPredMiss(branchPredMiss),
    .branchPredMissDetectedOnDecode(branchPredMissDetectedOnDecode),
    .clearReq(clearReq), .snapshotReq(snapshotReq), .snapshotBusy(snapshotBusy),
    .snap(u_snap), .perfCounter(perfCounter));

  typedef struct {
    int     idx;
    longint data;
  } word_t;

  longint      m_cnt [NUM_PERF_COUNTERS];
  word_t       m_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_xfer = 0;
  logic [31:0] got [NUM_PERF_COUNTERS];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint bump(input longint v, input longint inc);
    longint s = v + inc;
`ifdef RSD_PERF_COUNTER_SATURATE_EN
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`else
    s = s % 64'h1_0000_0000;
`endif
    return s;
  endfunction

  task automatic quiet_events();
    icMiss = 0; loadMiss = 0; storeMiss = 0; storeLoadForwardingFail = 0;
    memDepPredMiss = 0; branchPredMiss = 0; branchPredMissDetectedOnDecode = 0;
  endtask

  task automatic rand_events();
    icMiss = 1'($urandom); loadMiss = 2'($urandom); storeMiss = 1'($urandom);
    storeLoadForwardingFail = 2'($urandom); memDepPredMiss = 2'($urandom);
    branchPredMiss = 2'($urandom); branchPredMissDetectedOnDecode = 2'($urandom);
  endtask

  task automatic check_all();
    PerfCounterPath e;
    e.numIC_Miss                        = DataPath'(m_cnt[0]);
    e.numLoadMiss                       = DataPath'(m_cnt[1]);
    e.numStoreMiss                      = DataPath'(m_cnt[2]);
    e.numStoreLoadForwardingFail        = DataPath'(m_cnt[3]);
    e.numMemDepPredMiss                 = DataPath'(m_cnt[4]);
    e.numBranchPredMiss                 = DataPath'(m_cnt[5]);
    e.numBranchPredMissDetectedOnDecode = DataPath'(m_cnt[6]);
    chk("perfCounter", 256'(perfCounter), 256'(e));
    chk("busy", 256'(snapshotBusy), 256'(m_q.size() != 0));
    chk("valid", 256'(u_snap.snapOutValid), 256'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("index", 256'(u_snap.snapOutIndex), 256'(m_q[0].idx));
      chk("data", 256'(u_snap.snapOutData), 256'(DataPath'(m_q[0].data)));
      chk("last", 256'(u_snap.snapOutLast), 256'(m_q[0].idx == 6));
    end
  endtask

  // Model what the coming edge does, advance one clock, then compare.
  task automatic cycle();
    longint inc [NUM_PERF_COUNTERS];
    bit idle;
    idle = (m_q.size() == 0);
    if (u_snap.snapOutValid && u_snap.snapOutReady) begin
      n_xfer++;
      got[u_snap.snapOutIndex] = u_snap.snapOutData;
    end
    inc[0] = longint'(icMiss);
    inc[1] = longint'($countones(loadMiss));
    inc[2] = longint'(storeMiss);
    inc[3] = longint'($countones(storeLoadForwardingFail));
    inc[4] = longint'($countones(memDepPredMiss));
    inc[5] = longint'($countones(branchPredMiss));
    inc[6] = longint'($countones(branchPredMissDetectedOnDecode));
    if (!rstN) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_q.delete();
    end else begin
      if (!idle && u_snap.snapOutReady) void'(m_q.pop_front());
      if (idle && snapshotReq) begin
        foreach (m_cnt[k]) m_q.push_back('{idx: k, data: m_cnt[k]});
      end
      foreach (m_cnt[k]) begin
        if (clearReq) m_cnt[k] = 0;
        else if (countEnable) m_cnt[k] = bump(m_cnt[k], inc[k]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Run until the model's stream empties; ready follows pat, one extra request at req_at.
  task automatic drain(input logic [3:0] pat, input int req_at, input bit ev);
    n_xfer = 0;
    for (int i = 0; i < 60 && m_q.size() != 0; i++) begin
      u_snap.snapOutReady = pat[i % 4];
      snapshotReq = (i == req_at);
      if (ev) rand_events();
      else quiet_events();
      cycle();
    end
    snapshotReq = 0;
    quiet_events();
    chk("drain_idle", 256'(snapshotBusy), 256'(0));
    chk("xfer_count", 256'(n_xfer), 256'(7));
  endtask

  initial begin
    foreach (m_cnt[k]) m_cnt[k] = 0;
    rstN = 0; countEnable = 1; clearReq = 0; snapshotReq = 0;
    u_snap.snapOutReady = 0;
    quiet_events();
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_index", 256'(u_snap.snapOutIndex), 256'(0));
    chk("rst_data", 256'(u_snap.snapOutData), 256'(0));
    chk("rst_last", 256'(u_snap.snapOutLast), 256'(0));
    rstN = 1;
    repeat (10) cycle();

    // Two load lanes for five cycles, then hold with counting disabled.
    loadMiss = 2'b11;
    repeat (5) cycle();
    chk("load_ten", 256'(perfCounter.numLoadMiss), 256'(10));
    countEnable = 0;
    repeat (5) cycle();
    chk("load_hold", 256'(perfCounter.numLoadMiss), 256'(10));
    countEnable = 1;
    loadMiss = 0;

    // Preload, then read-and-clear with a colliding icMiss event.
    clearReq = 1; cycle(); clearReq = 0;
    icMiss = 1; repeat (3) cycle(); icMiss = 0;
    branchPredMiss = 2'b11; repeat (2) cycle(); branchPredMiss = 0;
    snapshotReq = 1; clearReq = 1; icMiss = 1;
    cycle();
    snapshotReq = 0; clearReq = 0; icMiss = 0;
    chk("rc_ic_zero", 256'(perfCounter.numIC_Miss), 256'(0));
    chk("rc_br_zero", 256'(perfCounter.numBranchPredMiss), 256'(0));
    drain(4'b1111, -1, 1'b0);
    chk("word0", 256'(got[0]), 256'(3));
    chk("word5", 256'(got[5]), 256'(4));

    // Stalling consumer, live events, ignored mid-stream request.
    snapshotReq = 1; rand_events(); cycle(); snapshotReq = 0;
    drain(4'b1001, 3, 1'b1);
    // Back-to-back: request right after the last transfer.
    snapshotReq = 1; cycle(); snapshotReq = 0;
    chk("b2b_valid", 256'(u_snap.snapOutValid), 256'(1));
    drain(4'b1101, 2, 1'b1);

    // Wrap or saturate at the counter limit.
    clearReq = 1; cycle(); clearReq = 0;
    dut.u_acc_store_miss.r_count = 32'hFFFF_FFFF;
    m_cnt[2] = 64'hFFFF_FFFF;
    storeMiss = 1; cycle(); storeMiss = 0;
`ifdef RSD_PERF_COUNTER_SATURATE_EN
    chk("store_limit", 256'(perfCounter.numStoreMiss), 256'(32'hFFFF_FFFF));
`else
    chk("store_limit", 256'(perfCounter.numStoreMiss), 256'(0));
`endif

    // Reset while word 3 is on the stream.
    loadMiss = 2'b01; icMiss = 1; repeat (4) cycle(); quiet_events();
    snapshotReq = 1; cycle(); snapshotReq = 0;
    u_snap.snapOutReady = 1;
    repeat (3) cycle();
    chk("at_word3", 256'(u_snap.snapOutIndex), 256'(3));
    rstN = 0; cycle(); rstN = 1;
    chk("rst_valid", 256'(u_snap.snapOutValid), 256'(0));
    chk("rst_counts", 256'(perfCounter), 256'(0));
    snapshotReq = 1; cycle(); snapshotReq = 0;
    drain(4'b1111, -1, 1'b0);
    foreach (got[k]) chk("zero_word", 256'(got[k]), 256'(0));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_events();
      countEnable = ($urandom % 8) != 0;
      clearReq = ($urandom % 24) == 0;
      snapshotReq = ($urandom % 10) == 0;
      u_snap.snapOutReady = 1'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
